// File: rtl/ahb_slave_mem_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the responder state type.
// Used by ahb_slave_mem and ahb_slave_mem_wstrb (import ahb_pkg::*).
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus bundle between an interconnect (master
// modport) and a responder (slave modport).
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY/HWDATA : toward the responder
//   HRDATA/HREADYOUT/HRESP                       : back from the responder
interface ahb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem_wstrb.sv
// ahb_slave_mem_wstrb: byte-lane strobe decode from transfer size and the
// low address bits, plus an alignment-violation flag.
//   size_i     : HSIZE
//   off_i      : HADDR[1:0]
//   strb_o     : one bit per byte lane of the 32-bit word
//   misalign_o : half on an odd address, or word not on a 4-byte boundary
// Sizes above a word give an empty strobe; the caller rejects them.
module ahb_slave_mem_wstrb
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] off_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: begin
        case (off_i)
          2'd0:    strb_o = 4'b0001;
          2'd1:    strb_o = 4'b0010;
          2'd2:    strb_o = 4'b0100;
          default: strb_o = 4'b1000;
        endcase
      end
      HSIZE_HALF: begin
        misalign_o = off_i[0];
        strb_o     = off_i[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        misalign_o = (off_i != 2'd0);
        strb_o     = 4'b1111;
      end
      default: strb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite responder backed by a DEPTH x 32-bit register
// array, with WAIT_STATES HREADYOUT-low cycles per OKAY data phase and a
// two-cycle ERROR response for illegal accesses.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus (slave)   : AHB-Lite signals, see ahb_slave_mem_if
//
// state  | meaning
// S_IDLE | ready; final data-phase cycle when a transfer is pending
// S_WAIT | inserting wait states, HREADYOUT low
// S_ERR1 | first ERROR cycle, HRESP high, HREADYOUT low
// S_ERR2 | second ERROR cycle, HRESP high, HREADYOUT high
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_slave_mem_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  slv_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_valid_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       mem_q [DEPTH];

  logic [3:0] strb;
  logic       misalign;
  logic       accept;
  logic       illegal;
  logic       complete;

  ahb_slave_mem_wstrb u_wstrb (
    .size_i     (bus.HSIZE),
    .off_i      (bus.HADDR[1:0]),
    .strb_o     (strb),
    .misalign_o (misalign)
  );

  // Accepts are only honoured while ready in IDLE; an accept during ERR2 is dropped.
  assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & (state_q == S_IDLE);
  assign illegal  = (bus.HSIZE > HSIZE_WORD) | misalign |
                    (|bus.HADDR[ADDR_WIDTH-1:IDX_W+2]);
  assign complete = (state_q == S_IDLE) & dp_valid_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    write_d    = write_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    case (state_q)
      S_IDLE: begin
        dp_valid_d = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = S_ERR1;
          end else begin
            dp_valid_d = 1'b1;
            write_d    = bus.HWRITE;
            idx_d      = bus.HADDR[IDX_W+1:2];
            strb_d     = strb;
            if (WAIT_STATES != 0) begin
              state_d = S_WAIT;
              cnt_d   = WS_M1;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      strb_q     <= strb_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (complete && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign bus.HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (complete && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Three responders (0, 2 and 3 wait states) share one bus driver; cur picks
// which one is selected and observed. Expected responses come from a
// byte-array memory model and the transfer rules, not from the RTL.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  localparam int DEPTH = 16;
  localparam int NDUT  = 3;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef enum int { K_NONE, K_LEGAL, K_ILL } kind_t;

  logic        hclk = 1'b0;
  logic        hrst_n = 1'b0;
  int          cur = 0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;
  logic [31:0] hwdata = '0;

  logic        rdy_v  [NDUT];
  logic        resp_v [NDUT];
  logic [31:0] rdat_v [NDUT];
  logic        o_rdy, o_resp;
  logic [31:0] o_rdat;

  int ws_tab [NDUT] = '{0, 2, 3};
  logic [31:0] mdl [NDUT][DEPTH];
  op_t opq[$];
  int n_vec = 0;
  int n_miss = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem_if #(.ADDR_WIDTH(32)) bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].HSEL   = hsel && (cur == g);
    assign bus[g].HADDR  = haddr;
    assign bus[g].HWRITE = hwrite;
    assign bus[g].HSIZE  = hsize;
    assign bus[g].HTRANS = htrans;
    assign bus[g].HWDATA = hwdata;
    assign bus[g].HREADY = bus[g].HREADYOUT;
    assign rdy_v[g]  = bus[g].HREADYOUT;
    assign resp_v[g] = bus[g].HRESP;
    assign rdat_v[g] = bus[g].HRDATA;

    ahb_slave_mem #(
      .ADDR_WIDTH  (32),
      .DEPTH       (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .HCLK    (hclk),
      .HRESETn (hrst_n),
      .bus     (bus[g])
    );
  end

  always_comb begin
    o_rdy  = rdy_v[cur];
    o_resp = resp_v[cur];
    o_rdat = rdat_v[cur];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h (dut %0d, t=%0t)", tag, obs, exp, cur, $time);
    end
  endtask

  function automatic kind_t classify(input op_t op);
    if (!(op.sel && op.trans[1])) return K_NONE;
    if (op.size > 3'd2) return K_ILL;
    if (op.addr % (32'd1 << op.size) != 0) return K_ILL;
    if (op.addr >= DEPTH * 4) return K_ILL;
    return K_LEGAL;
  endfunction

  task automatic model_write(input op_t op);
    int nb, lane, w;
    nb = 1 << op.size;
    w  = int'(op.addr / 4);
    for (int b = 0; b < nb; b++) begin
      lane = int'(op.addr % 4) + b;
      mdl[cur][w][8*lane +: 8] = op.wdata[8*lane +: 8];
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
  endtask

  task automatic drive(input op_t op);
    hsel = op.sel; htrans = op.trans; hwrite = op.wr; haddr = op.addr; hsize = op.size;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  function automatic op_t mk(input bit sel, input logic [1:0] tr, input bit wr,
                             input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    op_t o;
    o.sel = sel; o.trans = tr; o.wr = wr; o.addr = a; o.size = sz; o.wdata = wd;
    return o;
  endfunction

  // Pipelined master: a new address phase is presented in the cycle the
  // previous data phase is expected to complete; IDLE follows every ERROR.
  task automatic run_queue();
    op_t   dp;
    kind_t kind;
    bit    dp_v, done, e_rdy, e_resp;
    logic [31:0] e_rdat;
    int    k, budget;
    dp_v = 0; k = 0; budget = 0; kind = K_NONE;
    dp = mk(0, HTRANS_IDLE, 0, 0, 0, 0);
    forever begin
      @(negedge hclk);
      budget++;
      if (budget > 4000) begin
        chk("queue_timeout", 32'(budget), 32'd4000);
        break;
      end
      done = 1'b1;
      if (dp_v) begin
        if (k == 0) hwdata = dp.wdata;
        e_rdat = 32'h0;
        case (kind)
          K_LEGAL: begin
            e_rdy = (k == ws_tab[cur]); e_resp = 1'b0;
            if (e_rdy && !dp.wr) e_rdat = mdl[cur][dp.addr / 4];
          end
          K_ILL:   begin e_rdy = (k == 1); e_resp = 1'b1; end
          default: begin e_rdy = 1'b1; e_resp = 1'b0; end
        endcase
        chk("hreadyout", 32'(o_rdy), 32'(e_rdy));
        chk("hresp", 32'(o_resp), 32'(e_resp));
        chk("hrdata", o_rdat, e_rdat);
        done = e_rdy;
        if (done && kind == K_LEGAL && dp.wr) model_write(dp);
        if (!done) k++;
      end
      if (done) begin
        if (dp_v && kind == K_ILL) begin
          drive_idle();
          dp = mk(0, HTRANS_IDLE, 0, 0, 0, 0); kind = K_NONE; k = 0;
        end else if (opq.size() != 0) begin
          dp = opq.pop_front(); kind = classify(dp); k = 0; dp_v = 1;
          drive(dp);
        end else if (dp_v) begin
          drive_idle(); dp_v = 0;
        end else begin
          break;
        end
      end else begin
        drive_idle();
      end
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    int r;
    o.sel   = ($urandom_range(0, 9) != 0);
    o.trans = ($urandom_range(0, 4) != 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
    o.wr    = $urandom_range(0, 1) != 0;
    o.wdata = $urandom;
    r = $urandom_range(0, 9);
    if (r < 8)       o.addr = 32'($urandom_range(0, DEPTH*4 - 1));
    else if (r == 8) o.addr = 32'(DEPTH*4 + $urandom_range(0, 63));
    else             o.addr = $urandom;
    if ($urandom_range(0, 9) == 0) o.size = 3'($urandom_range(3, 7));
    else                           o.size = 3'($urandom_range(0, 2));
    if (o.size <= 3'd2 && $urandom_range(0, 9) < 7)
      o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
    return o;
  endfunction

  initial begin
    clear_model();
    repeat (3) @(negedge hclk);
    for (int d = 0; d < NDUT; d++) begin
      cur = d; #1;
      chk("rst_hreadyout", 32'(o_rdy), 32'd1);
      chk("rst_hresp", 32'(o_resp), 32'd0);
      chk("rst_hrdata", o_rdat, 32'd0);
    end
    hrst_n = 1'b1;

    // zero-wait back-to-back write/read, byte merge, errors, non-accepts
    cur = 0;
    opq.push_back(mk(1, HTRANS_NONSEQ, 1, 32'h08, HSIZE_WORD, 32'hDEADBEEF));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h08, HSIZE_WORD, 32'h0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 1, 32'h04, HSIZE_WORD, 32'h11223344));
    opq.push_back(mk(1, HTRANS_NONSEQ, 1, 32'h05, HSIZE_BYTE, 32'h0000AA00));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h04, HSIZE_WORD, 32'h0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 1, 32'h02, HSIZE_WORD, 32'hBADBAD01));
    opq.push_back(mk(1, HTRANS_NONSEQ, 1, 32'(DEPTH*4), HSIZE_WORD, 32'hBADBAD02));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h00, HSIZE_WORD, 32'h0));
    opq.push_back(mk(1, HTRANS_IDLE,   1, 32'h0C, HSIZE_WORD, 32'h55555555));
    opq.push_back(mk(1, HTRANS_BUSY,   1, 32'h0C, HSIZE_WORD, 32'h66666666));
    opq.push_back(mk(0, HTRANS_NONSEQ, 1, 32'h0C, HSIZE_WORD, 32'h77777777));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 32'h0));
    opq.push_back(mk(1, HTRANS_SEQ,    1, 32'h0E, HSIZE_HALF, 32'hCAFE0000));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 32'h0));
    run_queue();

    // two wait states: read of reset memory
    cur = 1;
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h00, HSIZE_WORD, 32'h0));
    run_queue();

    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      for (int i = 0; i < 80; i++) opq.push_back(rand_op());
      for (int i = 0; i < DEPTH; i++) opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'(4*i), HSIZE_WORD, 32'h0));
      run_queue();
    end

    // reset during a wait cycle of a write on the 3-wait-state responder
    cur = 2;
    @(negedge hclk);
    drive(mk(1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'h0));
    @(negedge hclk);
    hwdata = 32'h12345678; drive_idle();
    chk("wait0_hreadyout", 32'(o_rdy), 32'd0);
    @(negedge hclk);
    chk("wait1_hreadyout", 32'(o_rdy), 32'd0);
    hrst_n = 1'b0; #1;
    chk("midrst_hreadyout", 32'(o_rdy), 32'd1);
    chk("midrst_hresp", 32'(o_resp), 32'd0);
    @(negedge hclk);
    hrst_n = 1'b1;
    clear_model();
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 0, 32'h08, HSIZE_WORD, 32'h0));
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
